// File: rtl/regfile_wb_arbiter.sv
// Three-requester register-file write-back arbiter with a per-register pending scoreboard.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority 2 > 1 > 0 otherwise.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_valid,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      req_ready,
  output logic            wren,
  output logic [AW-1:0]   wr,
  output logic [DW-1:0]   wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_addr,
  input  logic [AW-1:0]   q_addr1,
  input  logic [AW-1:0]   q_addr2,
  output logic            q_busy1,
  output logic            q_busy2
);

  localparam int NREG = 1 << AW;

  logic [2:0]      grant_s;
  logic            xfer_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;
  logic [NREG-1:0] pend_r;
  logic [NREG-1:0] pend_nxt_s;
  logic            wren_r;
  logic [AW-1:0]   wr_r;
  logic [DW-1:0]   wd_r;

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] ptr_r;  // first requester examined this cycle

  // round-robin grant starting the search at ptr_r
  always_comb begin
    grant_s = 3'b000;
    case (ptr_r)
      2'd1: begin
        if      (req_valid[1]) grant_s = 3'b010;
        else if (req_valid[2]) grant_s = 3'b100;
        else if (req_valid[0]) grant_s = 3'b001;
        else                   grant_s = 3'b000;
      end
      2'd2: begin
        if      (req_valid[2]) grant_s = 3'b100;
        else if (req_valid[0]) grant_s = 3'b001;
        else if (req_valid[1]) grant_s = 3'b010;
        else                   grant_s = 3'b000;
      end
      default: begin
        if      (req_valid[0]) grant_s = 3'b001;
        else if (req_valid[1]) grant_s = 3'b010;
        else if (req_valid[2]) grant_s = 3'b100;
        else                   grant_s = 3'b000;
      end
    endcase
  end

  // pointer moves past the granted requester only when a transfer happens
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= 2'd0;
    end else if (xfer_s) begin
      case (grant_s)
        3'b001:  ptr_r <= 2'd1;
        3'b010:  ptr_r <= 2'd2;
        3'b100:  ptr_r <= 2'd0;
        default: ptr_r <= ptr_r;
      endcase
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // fixed priority: mul/div over load over ALU
  always_comb begin
    grant_s = 3'b000;
    if      (req_valid[2]) grant_s = 3'b100;
    else if (req_valid[1]) grant_s = 3'b010;
    else if (req_valid[0]) grant_s = 3'b001;
    else                   grant_s = 3'b000;
  end
`endif

  assign req_ready = rst ? grant_s : 3'b000;
  assign xfer_s    = |(req_valid & req_ready);

  // route the granted requester's address and data
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    case (req_ready)
      3'b001: begin
        sel_addr_s = req_addr[0*AW +: AW];
        sel_data_s = req_data[0*DW +: DW];
      end
      3'b010: begin
        sel_addr_s = req_addr[1*AW +: AW];
        sel_data_s = req_data[1*DW +: DW];
      end
      3'b100: begin
        sel_addr_s = req_addr[2*AW +: AW];
        sel_data_s = req_data[2*DW +: DW];
      end
      default: begin
        sel_addr_s = '0;
        sel_data_s = '0;
      end
    endcase
  end

  // claim beats clear on the same register; register 0 is never pending
  always_comb begin
    pend_nxt_s = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt_s[i] = (i != 0) &&
                      ((issue_valid && (issue_addr == AW'(i))) ||
                       (pend_r[i] && !(xfer_s && (sel_addr_s == AW'(i)))));
    end
  end

  // write port and scoreboard state
  always_ff @(posedge clk) begin
    if (!rst) begin
      wren_r <= 1'b0;
      wr_r   <= '0;
      wd_r   <= '0;
      pend_r <= '0;
    end else begin
      wren_r <= xfer_s && (sel_addr_s != '0);
      if (xfer_s) begin
        wr_r <= sel_addr_s;
        wd_r <= sel_data_s;
      end
      pend_r <= pend_nxt_s;
    end
  end

  assign wren = wren_r;
  assign wr   = wr_r;
  assign wd   = wd_r;

  // the write cycle itself still counts as busy for hazard queries
  assign q_busy1 = pend_r[q_addr1] | (wren_r & (wr_r != '0) & (wr_r == q_addr1));
  assign q_busy2 = pend_r[q_addr2] | (wren_r & (wr_r != '0) & (wr_r == q_addr2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, starvation sequence and
// randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;
  logic            wren;
  logic [AW-1:0]   wr;
  logic [DW-1:0]   wd;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic [AW-1:0]   q_addr1;
  logic [AW-1:0]   q_addr2;
  logic            q_busy1;
  logic            q_busy2;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wren(wren), .wr(wr), .wd(wd),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .q_addr1(q_addr1),
    .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  int nvec = 0;
  int nfail = 0;

  // behavioural model state
  bit [31:0]   m_pend;
  logic        m_wren;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_start;

  typedef struct {
    logic        r;
    logic [2:0]  v;
    logic [14:0] a;
    logic [95:0] d;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic [2:0]  er;
    logic        ew;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic r, input logic [2:0] v,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic iv, input logic [4:0] ia,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic [2:0] er, input logic ew, input logic [4:0] ewr,
                              input logic [31:0] ewd, input logic eb1, input logic eb2);
    vec_t t;
    t.r = r; t.v = v; t.a = {a2, a1, a0}; t.d = {d2, d1, d0};
    t.iv = iv; t.ia = ia; t.q1 = q1; t.q2 = q2;
    t.er = er; t.ew = ew; t.ewr = ewr; t.ewd = ewd; t.eb1 = eb1; t.eb2 = eb2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] mgrant(input logic r, input logic [2:0] v);
    if (!r || v == 3'b000) return 3'b000;
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_start + k) % 3;
      if (v[i]) return 3'(1 << i);
    end
    return 3'b000;
`else
    if (v[2]) return 3'b100;
    if (v[1]) return 3'b010;
    return 3'b001;
`endif
  endfunction

  function automatic logic mbusy(input logic [4:0] q);
    return (q != 5'd0 && m_pend[q]) || (m_wren && m_wr != 5'd0 && m_wr == q);
  endfunction

  task automatic drive(input logic r, input logic [2:0] v, input logic [14:0] a,
                       input logic [95:0] d, input logic iv, input logic [4:0] ia,
                       input logic [4:0] q1, input logic [4:0] q2);
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a; req_data = d;
    issue_valid = iv; issue_addr = ia; q_addr1 = q1; q_addr2 = q2;
    #1;
  endtask

  task automatic check_model();
    chk("ready", 64'(req_ready), 64'(mgrant(rst, req_valid)));
    chk("wren",  64'(wren), 64'(m_wren));
    chk("wr",    64'(wr), 64'(m_wr));
    chk("wd",    64'(wd), 64'(m_wd));
    chk("busy1", 64'(q_busy1), 64'(mbusy(q_addr1)));
    chk("busy2", 64'(q_busy2), 64'(mbusy(q_addr2)));
  endtask

  // advance one clock and apply the specification's update rules to the model
  task automatic step();
    logic [2:0] g;
    int idx;
    logic [4:0] ad;
    g = mgrant(rst, req_valid);
    @(posedge clk);
    if (!rst) begin
      m_pend = 32'h0; m_wren = 1'b0; m_wr = 5'd0; m_wd = 32'h0; m_start = 0;
    end else begin
      if (g != 3'b000) begin
        idx = g[2] ? 2 : (g[1] ? 1 : 0);
        ad = req_addr[idx*5 +: 5];
        m_wren = (ad != 5'd0);
        m_wr = ad;
        m_wd = req_data[idx*32 +: 32];
        m_pend[ad] = 1'b0;
        m_start = (idx + 1) % 3;
      end else begin
        m_wren = 1'b0;
      end
      if (issue_valid && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] Z;
    int c0;
    int c2;
    Z = 32'h0;
    rst = 1'b0; req_valid = 3'b000; req_addr = 15'h0; req_data = 96'h0;
    issue_valid = 1'b0; issue_addr = 5'd0; q_addr1 = 5'd0; q_addr2 = 5'd0;
    m_pend = 32'h0; m_wren = 1'b0; m_wr = 5'd0; m_wd = 32'h0; m_start = 0;

    tbl[0]  = mk(1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, Z, Z, 1'b0, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, Z, Z, 1'b0, 5'd0, 5'd5, 5'd0, 3'b001, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd5, 5'd0, 3'b000, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 3'b010, 5'd0, 5'd0, 5'd0, Z, 32'h1234, Z, 1'b0, 5'd0, 5'd5, 5'd0, 3'b010, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b1, 5'd7, 5'd7, 5'd0, 3'b000, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd7, 5'd0, 3'b000, 1'b0, 5'd0, Z, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 3'b001, 5'd7, 5'd0, 5'd0, 32'h77, Z, Z, 1'b0, 5'd0, 5'd7, 5'd0, 3'b001, 1'b0, 5'd0, Z, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd7, 5'd0, 3'b000, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd7, 5'd0, 3'b000, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 3'b001, 5'd7, 5'd0, 5'd0, 32'h88, Z, Z, 1'b1, 5'd7, 5'd7, 5'd0, 3'b001, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd7, 5'd0, 3'b000, 1'b1, 5'd7, 32'h88, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd7, 5'd7, 3'b000, 1'b0, 5'd0, Z, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 32'h99, Z, Z, 1'b1, 5'd9, 5'd7, 5'd9, 3'b000, 1'b0, 5'd0, Z, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd7, 5'd9, 3'b000, 1'b0, 5'd0, Z, 1'b0, 1'b0);
`ifdef WB_ROUND_ROBIN_EN
    tbl[15] = mk(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
`else
    tbl[15] = mk(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 5'd0, Z, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 3'b011, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 3'b001, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
`endif
    tbl[19] = mk(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, Z, Z, Z, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, Z, 1'b0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'b000, 15'h0, 96'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      step();
    end

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].iv, tbl[i].ia, tbl[i].q1, tbl[i].q2);
      chk($sformatf("t%0d_ready", i), 64'(req_ready), 64'(tbl[i].er));
      chk($sformatf("t%0d_wren", i),  64'(wren), 64'(tbl[i].ew));
      chk($sformatf("t%0d_busy1", i), 64'(q_busy1), 64'(tbl[i].eb1));
      chk($sformatf("t%0d_busy2", i), 64'(q_busy2), 64'(tbl[i].eb2));
      if (tbl[i].ew) begin
        chk($sformatf("t%0d_wr", i), 64'(wr), 64'(tbl[i].ewr));
        chk($sformatf("t%0d_wd", i), 64'(wd), 64'(tbl[i].ewd));
      end
      step();
    end

    // starvation: ALU and mul/div both held valid for ten cycles after reset
    drive(1'b0, 3'b000, 15'h0, 96'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    c0 = 0;
    c2 = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'b101, {5'd12, 5'd0, 5'd11}, {32'hC0DE0000 + 32'(i), 32'h0, 32'hA0000000 + 32'(i)},
            1'b0, 5'd0, 5'd11, 5'd12);
      check_model();
      if (req_ready[0]) c0++;
      if (req_ready[2]) c2++;
      step();
    end
`ifdef WB_ROUND_ROBIN_EN
    chk("starve_alu", 64'(c0), 64'd5);
    chk("starve_muldiv", 64'(c2), 64'd5);
`else
    chk("starve_alu", 64'(c0), 64'd0);
    chk("starve_muldiv", 64'(c2), 64'd10);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)),
            {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
            {32'($urandom), 32'($urandom), 32'($urandom)},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      check_model();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
